// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and its datapath/memory.
// Handshake: mem_ready is sampled by the controller on the rising clock edge only while a memory state holds MemRead/MemWrite.
interface multicycle_controller_if;
  logic [5:0] opcode;
  logic [5:0] func;
  logic       zero;
  logic       mem_ready;

  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] RegDst;
  logic [1:0] MemtoReg;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUop;
  logic [1:0] PCSource;

  logic [3:0] state;
  logic       instr_done;
  logic       illegal_op;

  modport slave (
    input  opcode, func, zero, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite,
    output RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUop, PCSource,
    output state, instr_done, illegal_op
  );

  modport master (
    output opcode, func, zero, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite,
    input  RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUop, PCSource,
    input  state, instr_done, illegal_op
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle MIPS-subset control FSM: one state per instruction phase, Moore outputs
// plus mem_ready-qualified strobes in FETCH/MEM_WRITE.
module multicycle_controller (
  input  logic clock,
  input  logic reset,
  multicycle_controller_if.slave bus
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JAL       = 4'd9,
    S_JR        = 4'd10,
    S_I_EXEC    = 4'd11,
    S_I_WB      = 4'd12,
    S_TRAP      = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_JR    = 6'h08;

  state_t state_q;
  state_t state_d;

  logic       pc_write;
  logic       pc_write_cond;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic [1:0] reg_dst;
  logic [1:0] mem_to_reg;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       done;
  logic       illegal;

  function automatic logic r_func_legal(input logic [5:0] f);
    return (f == 6'h20) || (f == 6'h24) || (f == 6'h27) || (f == 6'h2A) || (f == FN_SLL);
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 2'd0;
    mem_to_reg    = 2'd0;
    alu_src_a     = 2'd0;
    alu_src_b     = 2'd0;
    alu_op        = 2'd0;
    pc_source     = 2'd0;
    done          = 1'b0;
    illegal       = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        if (bus.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        // ALUOut latches PC+4 + (imm<<2) so BRANCH can use it as the target.
        alu_src_b = 2'd3;
        case (bus.opcode)
          OP_RTYPE: begin
            if (bus.func == FN_JR)           state_d = S_JR;
            else if (r_func_legal(bus.func)) state_d = S_R_EXEC;
            else                             state_d = S_TRAP;
          end
          OP_LW, OP_SW:     state_d = S_MEM_ADDR;
          OP_BEQ:           state_d = S_BRANCH;
          OP_JAL:           state_d = S_JAL;
          OP_ADDI, OP_ANDI: state_d = S_I_EXEC;
          default:          state_d = S_TRAP;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 2'd1;
        alu_src_b = 2'd2;
        if (bus.opcode == OP_LW)      state_d = S_MEM_READ;
        else if (bus.opcode == OP_SW) state_d = S_MEM_WRITE;
        else                          state_d = S_TRAP;
      end
      S_MEM_READ: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        if (bus.mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        mem_to_reg = 2'd1;
        reg_write  = 1'b1;
        done       = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WRITE: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        if (bus.mem_ready) begin
          done    = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_R_EXEC: begin
        alu_op    = 2'd2;
        alu_src_a = (bus.func == FN_SLL) ? 2'd2 : 2'd1;
        state_d   = S_R_WB;
      end
      S_R_WB: begin
        reg_dst   = 2'd1;
        reg_write = 1'b1;
        done      = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 2'd1;
        alu_op        = 2'd1;
        pc_write_cond = 1'b1;
        pc_source     = 2'd1;
        done          = 1'b1;
        state_d       = S_FETCH;
      end
      S_JAL: begin
        // PC was already incremented in FETCH, so MemtoReg=2 links PC+4.
        reg_dst    = 2'd2;
        mem_to_reg = 2'd2;
        reg_write  = 1'b1;
        pc_write   = 1'b1;
        pc_source  = 2'd2;
        done       = 1'b1;
        state_d    = S_FETCH;
      end
      S_JR: begin
        pc_write  = 1'b1;
        pc_source = 2'd3;
        done      = 1'b1;
        state_d   = S_FETCH;
      end
      S_I_EXEC: begin
        alu_src_a = 2'd1;
        alu_src_b = 2'd2;
        alu_op    = (bus.opcode == OP_ANDI) ? 2'd3 : 2'd0;
        state_d   = S_I_WB;
      end
      S_I_WB: begin
        reg_write = 1'b1;
        done      = 1'b1;
        state_d   = S_FETCH;
      end
      S_TRAP: begin
        illegal = 1'b1;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Reset gates the decoded outputs so no strobe escapes while reset is held.
  assign bus.PCWrite     = reset ? 1'b0 : pc_write;
  assign bus.PCWriteCond = reset ? 1'b0 : pc_write_cond;
  assign bus.IorD        = reset ? 1'b0 : iord;
  assign bus.MemRead     = reset ? 1'b0 : mem_read;
  assign bus.MemWrite    = reset ? 1'b0 : mem_write;
  assign bus.IRWrite     = reset ? 1'b0 : ir_write;
  assign bus.RegWrite    = reset ? 1'b0 : reg_write;
  assign bus.RegDst      = reset ? 2'd0 : reg_dst;
  assign bus.MemtoReg    = reset ? 2'd0 : mem_to_reg;
  assign bus.ALUSrcA     = reset ? 2'd0 : alu_src_a;
  assign bus.ALUSrcB     = reset ? 2'd0 : alu_src_b;
  assign bus.ALUop       = reset ? 2'd0 : alu_op;
  assign bus.PCSource    = reset ? 2'd0 : pc_source;
  assign bus.instr_done  = reset ? 1'b0 : done;
  assign bus.illegal_op  = reset ? 1'b0 : illegal;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-instruction state traces and control checks.
module tb_multicycle_controller;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [3:0] exp_q[$];

  multicycle_controller_if bus();
  multicycle_controller dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_in(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic mr);
    bus.opcode    = op;
    bus.func      = fn;
    bus.zero      = z;
    bus.mem_ready = mr;
  endtask

  task automatic test_reset();
    set_in(6'h00, 6'h20, 1'b0, 1'b1);
    #1;
    n_cmp++; if (bus.state !== 4'd0) begin n_err++; $display("FAIL rst_state: got %0d want 0", bus.state); end
    n_cmp++; if ({bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite, bus.PCWriteCond} !== 5'b0) begin
      n_err++; $display("FAIL rst_wen: got %b want 00000", {bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite, bus.PCWriteCond}); end
    n_cmp++; if ({bus.instr_done, bus.illegal_op} !== 2'b00) begin n_err++; $display("FAIL rst_status: got %b want 00", {bus.instr_done, bus.illegal_op}); end
    tick();
    n_cmp++; if (bus.state !== 4'd0 || bus.PCWrite !== 1'b0) begin n_err++; $display("FAIL rst_held: state %0d pcw %b want 0/0", bus.state, bus.PCWrite); end
    reset = 1'b0;
    #1;
    n_cmp++; if (bus.IRWrite !== 1'b1 || bus.PCWrite !== 1'b1 || bus.ALUSrcB !== 2'd1) begin
      n_err++; $display("FAIL rst_first_fetch: irw %b pcw %b srcb %0d want 1/1/1", bus.IRWrite, bus.PCWrite, bus.ALUSrcB); end
  endtask

  task automatic test_add();
    logic [3:0] exp_s;
    int dones = 0;
    exp_q = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
    set_in(6'h00, 6'h20, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      #1;
      exp_s = exp_q.pop_front();
      n_cmp++; if (bus.state !== exp_s) begin n_err++; $display("FAIL add_state[%0d]: got %0d want %0d", i, bus.state, exp_s); end
      if (exp_s == 4'd1) begin
        n_cmp++; if (bus.ALUSrcB !== 2'd3 || bus.ALUSrcA !== 2'd0) begin n_err++; $display("FAIL add_decode_alu: srcb %0d srca %0d want 3/0", bus.ALUSrcB, bus.ALUSrcA); end
      end
      if (exp_s == 4'd6) begin
        n_cmp++; if (bus.ALUop !== 2'd2 || bus.ALUSrcA !== 2'd1) begin n_err++; $display("FAIL add_exec: op %0d srca %0d want 2/1", bus.ALUop, bus.ALUSrcA); end
      end
      if (exp_s == 4'd7) begin
        n_cmp++; if (bus.RegWrite !== 1'b1 || bus.RegDst !== 2'd1) begin n_err++; $display("FAIL add_wb: rw %b dst %0d want 1/1", bus.RegWrite, bus.RegDst); end
      end
      dones += int'(bus.instr_done);
      if (i < 4) tick();
    end
    n_cmp++; if (dones !== 1) begin n_err++; $display("FAIL add_done_count: got %0d want 1", dones); end
  endtask

  task automatic test_sll();
    set_in(6'h00, 6'h00, 1'b0, 1'b1);
    tick(); tick();
    #1;
    n_cmp++; if (bus.state !== 4'd6 || bus.ALUSrcA !== 2'd2) begin n_err++; $display("FAIL sll_srca: state %0d srca %0d want 6/2", bus.state, bus.ALUSrcA); end
    tick(); tick();
  endtask

  task automatic test_lw_wait();
    logic [3:0] exp_s;
    logic mr_a[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    exp_q = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
    for (int i = 0; i < 8; i++) begin
      set_in(6'h23, 6'h00, 1'b0, mr_a[i]);
      #1;
      exp_s = exp_q.pop_front();
      n_cmp++; if (bus.state !== exp_s) begin n_err++; $display("FAIL lw_state[%0d]: got %0d want %0d", i, bus.state, exp_s); end
      if (exp_s == 4'd3) begin
        n_cmp++; if (bus.MemRead !== 1'b1 || bus.IorD !== 1'b1) begin n_err++; $display("FAIL lw_memread[%0d]: rd %b iord %b want 1/1", i, bus.MemRead, bus.IorD); end
      end
      if (i < 6) begin
        n_cmp++; if (bus.RegWrite !== 1'b0) begin n_err++; $display("FAIL lw_early_rw[%0d]: got %b want 0", i, bus.RegWrite); end
      end
      if (exp_s == 4'd4) begin
        n_cmp++; if (bus.RegWrite !== 1'b1 || bus.MemtoReg !== 2'd1 || bus.instr_done !== 1'b1) begin
          n_err++; $display("FAIL lw_wb: rw %b m2r %0d done %b want 1/1/1", bus.RegWrite, bus.MemtoReg, bus.instr_done); end
      end
      if (i < 7) tick();
    end
  endtask

  task automatic test_sw();
    set_in(6'h2B, 6'h00, 1'b0, 1'b1);
    tick(); tick(); tick();
    #1;
    n_cmp++; if (bus.state !== 4'd5 || bus.MemWrite !== 1'b1 || bus.instr_done !== 1'b1) begin
      n_err++; $display("FAIL sw_write: state %0d mw %b done %b want 5/1/1", bus.state, bus.MemWrite, bus.instr_done); end
    tick();
    n_cmp++; if (bus.state !== 4'd0) begin n_err++; $display("FAIL sw_return: got %0d want 0", bus.state); end
  endtask

  task automatic test_beq();
    logic z_a[2] = '{1'b1, 1'b0};
    for (int k = 0; k < 2; k++) begin
      set_in(6'h04, 6'h00, z_a[k], 1'b1);
      tick(); tick();
      #1;
      n_cmp++; if (bus.state !== 4'd8 || bus.PCWriteCond !== 1'b1 || bus.PCSource !== 2'd1 || bus.PCWrite !== 1'b0) begin
        n_err++; $display("FAIL beq_z%0d: state %0d pwc %b src %0d pcw %b want 8/1/1/0", z_a[k], bus.state, bus.PCWriteCond, bus.PCSource, bus.PCWrite); end
      n_cmp++; if (bus.ALUop !== 2'd1 || bus.instr_done !== 1'b1) begin n_err++; $display("FAIL beq_alu_z%0d: op %0d done %b want 1/1", z_a[k], bus.ALUop, bus.instr_done); end
      tick();
    end
  endtask

  task automatic test_jal_jr();
    int cycles;
    set_in(6'h03, 6'h00, 1'b0, 1'b1);
    tick(); tick();
    #1;
    n_cmp++; if (bus.state !== 4'd9 || bus.RegDst !== 2'd2 || bus.MemtoReg !== 2'd2 || bus.PCSource !== 2'd2 || bus.PCWrite !== 1'b1) begin
      n_err++; $display("FAIL jal_ctrl: state %0d dst %0d m2r %0d src %0d pcw %b want 9/2/2/2/1", bus.state, bus.RegDst, bus.MemtoReg, bus.PCSource, bus.PCWrite); end
    tick();
    set_in(6'h00, 6'h08, 1'b0, 1'b1);
    tick(); tick();
    #1;
    n_cmp++; if (bus.state !== 4'd10 || bus.PCSource !== 2'd3 || bus.PCWrite !== 1'b1 || bus.RegWrite !== 1'b0) begin
      n_err++; $display("FAIL jr_ctrl: state %0d src %0d pcw %b rw %b want 10/3/1/0", bus.state, bus.PCSource, bus.PCWrite, bus.RegWrite); end
    tick();
    cycles = 0;
    set_in(6'h03, 6'h00, 1'b0, 1'b1);
    do begin tick(); cycles++; end while (bus.state !== 4'd0 && cycles < 20);
    n_cmp++; if (cycles !== 3) begin n_err++; $display("FAIL jal_latency: got %0d want 3", cycles); end
  endtask

  task automatic test_imm();
    set_in(6'h08, 6'h00, 1'b0, 1'b1);
    tick(); tick();
    #1;
    n_cmp++; if (bus.state !== 4'd11 || bus.ALUop !== 2'd0 || bus.ALUSrcB !== 2'd2) begin
      n_err++; $display("FAIL addi_exec: state %0d op %0d srcb %0d want 11/0/2", bus.state, bus.ALUop, bus.ALUSrcB); end
    tick();
    n_cmp++; if (bus.state !== 4'd12 || bus.RegWrite !== 1'b1 || bus.RegDst !== 2'd0) begin
      n_err++; $display("FAIL addi_wb: state %0d rw %b dst %0d want 12/1/0", bus.state, bus.RegWrite, bus.RegDst); end
    tick();
    set_in(6'h0C, 6'h00, 1'b0, 1'b1);
    tick(); tick();
    #1;
    n_cmp++; if (bus.state !== 4'd11 || bus.ALUop !== 2'd3) begin n_err++; $display("FAIL andi_exec: state %0d op %0d want 11/3", bus.state, bus.ALUop); end
    tick(); tick();
  endtask

  task automatic test_trap();
    logic [5:0] op_a[2] = '{6'h3F, 6'h00};
    logic [5:0] fn_a[2] = '{6'h00, 6'h11};
    for (int k = 0; k < 2; k++) begin
      set_in(op_a[k], fn_a[k], 1'b0, 1'b1);
      tick(); tick(); tick(); tick();
      #1;
      n_cmp++; if (bus.state !== 4'd13 || bus.illegal_op !== 1'b1) begin
        n_err++; $display("FAIL trap_enter[%0d]: state %0d ill %b want 13/1", k, bus.state, bus.illegal_op); end
      n_cmp++; if ({bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite, bus.PCWriteCond, bus.instr_done} !== 6'b0) begin
        n_err++; $display("FAIL trap_quiet[%0d]: got %b want 000000", k, {bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite, bus.PCWriteCond, bus.instr_done}); end
      reset = 1'b1;
      #1;
      n_cmp++; if (bus.state !== 4'd0 || bus.illegal_op !== 1'b0) begin
        n_err++; $display("FAIL trap_reset[%0d]: state %0d ill %b want 0/0", k, bus.state, bus.illegal_op); end
      #1;
      reset = 1'b0;
    end
  endtask

  task automatic test_async_reset_mem_write();
    set_in(6'h2B, 6'h00, 1'b0, 1'b1);
    tick();
    bus.mem_ready = 1'b0;
    tick(); tick(); tick();
    #1;
    n_cmp++; if (bus.state !== 4'd5 || bus.MemWrite !== 1'b1 || bus.instr_done !== 1'b0) begin
      n_err++; $display("FAIL sw_wait: state %0d mw %b done %b want 5/1/0", bus.state, bus.MemWrite, bus.instr_done); end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++; if (bus.state !== 4'd0 || bus.MemWrite !== 1'b0) begin
      n_err++; $display("FAIL async_rst: state %0d mw %b want 0/0", bus.state, bus.MemWrite); end
    #1;
    reset = 1'b0;
    tick();
    n_cmp++; if (bus.state !== 4'd0 || bus.MemRead !== 1'b1) begin
      n_err++; $display("FAIL post_rst_fetch: state %0d rd %b want 0/1", bus.state, bus.MemRead); end
  endtask

  initial begin
    set_in(6'h00, 6'h00, 1'b0, 1'b0);
    test_reset();
    test_add();
    test_sll();
    test_lw_wait();
    test_sw();
    test_beq();
    test_jal_jr();
    test_imm();
    test_trap();
    test_async_reset_mem_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
